div16_seq: RTL and testbench

- Iterative 16-bit restoring divider for the single-cycle datapath; runs the inverse of the ALU's add/shift path.
- Takes dividend/divisor with the same `sign` convention the ALU uses.
- Produces quotient, remainder and ALU-style flags after a fixed multi-cycle latency.
- Front end stalls on `busy` and captures results on `done`.

---
 rtl/div16_seq.sv | 182 ++++++++++++++++++
 tb/tb_div16_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div16_seq.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned operands,
// ALU-style flags. Divide-by-zero and signed -MIN/-1 bypass the iteration loop.
module div16_seq #(
  parameter int OPERAND_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] InA,
  input  logic [OPERAND_WIDTH-1:0] InB,
  input  logic                     sign,
  output logic                     busy,
  output logic                     done,
  output logic [OPERAND_WIDTH-1:0] Quo,
  output logic [OPERAND_WIDTH-1:0] Rem,
  output logic                     Sfl,
  output logic                     Zfl,
  output logic                     Ofl
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    pr_q, pr_d;
  logic [W-1:0]  pq_q, pq_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rmd_q, rmd_d;
  logic          sfl_q, sfl_d;
  logic          zfl_q, zfl_d;
  logic          ofl_q, ofl_d;

  logic          a_neg_s, b_neg_s;
  logic [W-1:0]  a_mag_s, b_mag_s;
  logic          div_zero_s, ovf_s;
  logic [W+1:0]  shifted_s, trial_s;
  logic          ge_s;
  logic [W:0]    pr_nx_s;
  logic [W-1:0]  pq_nx_s, quo_fin_s, rmd_fin_s;

  // Operand magnitudes, special-case detection and one restoring iteration.
  always_comb begin
    a_neg_s    = sign & InA[W-1];
    b_neg_s    = sign & InB[W-1];
    // Unsigned W-bit magnitude still represents |MIN| exactly.
    a_mag_s    = a_neg_s ? ({W{1'b0}} - InA) : InA;
    b_mag_s    = b_neg_s ? ({W{1'b0}} - InB) : InB;
    div_zero_s = (InB == {W{1'b0}});
    ovf_s      = sign & (InA == {1'b1, {(W-1){1'b0}}}) & (InB == {W{1'b1}});
    shifted_s  = {pr_q, pq_q[W-1]};
    trial_s    = shifted_s - {2'b00, dvs_q};
    ge_s       = ~trial_s[W+1];
    pr_nx_s    = ge_s ? trial_s[W:0] : shifted_s[W:0];
    pq_nx_s    = {pq_q[W-2:0], ge_s};
    quo_fin_s  = qneg_q ? ({W{1'b0}} - pq_nx_s) : pq_nx_s;
    rmd_fin_s  = rneg_q ? ({W{1'b0}} - pr_nx_s[W-1:0]) : pr_nx_s[W-1:0];
  end

  // Next-state logic for the control FSM, datapath and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    pq_d    = pq_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    sfl_d   = sfl_q;
    zfl_d   = zfl_q;
    ofl_d   = ofl_q;
    case (state_q)
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        pr_d  = pr_nx_s;
        pq_d  = pq_nx_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          quo_d   = quo_fin_s;
          rmd_d   = rmd_fin_s;
          sfl_d   = quo_fin_s[W-1];
          zfl_d   = (quo_fin_s == {W{1'b0}});
          ofl_d   = 1'b0;
        end else begin
          state_d = S_CALC;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          if (div_zero_s) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quo_d   = {W{1'b1}};
            rmd_d   = InA;
            sfl_d   = 1'b1;
            zfl_d   = 1'b0;
            ofl_d   = 1'b1;
          end else if (ovf_s) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quo_d   = {1'b1, {(W-1){1'b0}}};
            rmd_d   = {W{1'b0}};
            sfl_d   = 1'b1;
            zfl_d   = 1'b0;
            ofl_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            cnt_d   = CW'(W - 1);
            pr_d    = {(W+1){1'b0}};
            pq_d    = a_mag_s;
            dvs_d   = b_mag_s;
            qneg_d  = a_neg_s ^ b_neg_s;
            rneg_d  = a_neg_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CALC);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      pr_q    <= {(W+1){1'b0}};
      pq_q    <= {W{1'b0}};
      dvs_q   <= {W{1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= {W{1'b0}};
      rmd_q   <= {W{1'b0}};
      sfl_q   <= 1'b0;
      zfl_q   <= 1'b0;
      ofl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      pq_q    <= pq_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      sfl_q   <= sfl_d;
      zfl_q   <= zfl_d;
      ofl_q   <= ofl_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Quo  = quo_q;
  assign Rem  = rmd_q;
  assign Sfl  = sfl_q;
  assign Zfl  = zfl_q;
  assign Ofl  = ofl_q;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed and random operations compared against
// an integer-arithmetic reference, plus start-while-busy, mid-op reset and back-to-back.
module tb_div16_seq;

  logic        clk = 1'b0;
  logic        rst, start, sign;
  logic [15:0] InA, InB;
  logic        busy, done;
  logic [15:0] Quo, Rem;
  logic        Sfl, Zfl, Ofl;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] quo;
    logic [15:0] rem;
    logic        sfl;
    logic        zfl;
    logic        ofl;
  } exp_t;

  always #5 clk = ~clk;

  div16_seq #(.OPERAND_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .InA(InA), .InB(InB), .sign(sign),
    .busy(busy), .done(done), .Quo(Quo), .Rem(Rem), .Sfl(Sfl), .Zfl(Zfl), .Ofl(Ofl)
  );

  function automatic logic is_special(input logic [15:0] a, input logic [15:0] b, input logic s);
    return (b == 16'd0) || (s && a == 16'h8000 && b == 16'hFFFF);
  endfunction

  // Reference: plain integer division (truncating), remainder takes dividend sign.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int   sa, sb, qi, ri;
    if (b == 16'd0) begin
      e = '{quo: 16'hFFFF, rem: a, sfl: 1'b1, zfl: 1'b0, ofl: 1'b1};
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e = '{quo: 16'h8000, rem: 16'h0000, sfl: 1'b1, zfl: 1'b0, ofl: 1'b1};
    end else begin
      sa = s ? int'($signed(a)) : int'(a);
      sb = s ? int'($signed(b)) : int'(b);
      qi = sa / sb;
      ri = sa % sb;
      e.quo = qi[15:0];
      e.rem = ri[15:0];
      e.sfl = qi[15];
      e.zfl = (qi[15:0] == 16'd0);
      e.ofl = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input exp_t e);
    chk({tag, "_quo"}, {16'd0, Quo}, {16'd0, e.quo});
    chk({tag, "_rem"}, {16'd0, Rem}, {16'd0, e.rem});
    chk({tag, "_sfl"}, {31'd0, Sfl}, {31'd0, e.sfl});
    chk({tag, "_zfl"}, {31'd0, Zfl}, {31'd0, e.zfl});
    chk({tag, "_ofl"}, {31'd0, Ofl}, {31'd0, e.ofl});
  endtask

  // Drive one start pulse; returns #1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    InA = a; InB = b; sign = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
    exp_t e;
    int   n;
    int   lat_e;
    e     = model(a, b, s);
    lat_e = is_special(a, b, s) ? 0 : 16;
    issue(a, b, s);
    chk({tag, "_busy"}, {31'd0, busy}, (lat_e == 0) ? 32'd0 : 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, n, lat_e);
    chk_res(tag, e);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    exp_t e1, e2;
    int   n;
    int   dcount;
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b1; start = 1'b0; InA = 16'd0; InB = 16'd0; sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_res("rst", '{quo: 16'd0, rem: 16'd0, sfl: 1'b0, zfl: 1'b0, ofl: 1'b0});
    rst = 1'b0;

    run_op(16'd100,  16'd7,     1'b0, "u_basic");
    run_op(16'hFFF9, 16'd2,     1'b1, "s_mixed");
    run_op(16'hFFF9, 16'd2,     1'b0, "u_large");
    run_op(16'h1234, 16'd0,     1'b0, "divzero_u");
    run_op(16'hF000, 16'd0,     1'b1, "divzero_s");
    run_op(16'h8000, 16'hFFFF,  1'b1, "s_ovf");
    run_op(16'd3,    16'd5,     1'b0, "small");
    run_op(16'h8000, 16'd1,     1'b1, "s_min_1");
    run_op(16'h8000, 16'hFFFF,  1'b0, "u_8000_ffff");
    run_op(16'd37,   16'hFFF9,  1'b1, "s_pos_neg");

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 3 == 1) rb = 16'($urandom_range(1, 20));
      if (i % 8 == 5) rb = 16'd0;
      run_op(ra, rb, rs, "rand");
    end

    // start pulsed mid-operation must be ignored
    e1 = model(16'd1000, 16'd10, 1'b0);
    issue(16'd1000, 16'd10, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    InA = 16'd5; InB = 16'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("ign_lat", n, 11);
    chk_res("ign", e1);

    // reset mid-operation aborts with no done pulse
    issue(16'd777, 16'd3, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk_res("mrst", '{quo: 16'd0, rem: 16'd0, sfl: 1'b0, zfl: 1'b0, ofl: 1'b0});
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (done === 1'b1) dcount++;
    end
    chk("mrst_nodone", dcount, 0);

    // start held high through DONE: second op follows immediately
    e1 = model(16'd200, 16'd3, 1'b0);
    e2 = model(16'd50000, 16'd7, 1'b0);
    @(negedge clk);
    InA = 16'd200; InB = 16'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 InA = 16'd50000; InB = 16'd7;
    wait_done(n);
    chk("b2b_lat1", n, 16);
    chk_res("b2b1", e1);
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("b2b_gap", n + 1, 17);
    chk_res("b2b2", e2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
